// File: rtl/booth_mult_param.sv
// Iterative radix-2 Booth multiplier for MULT/MULTU: signed/unsigned, hi/lo product.
// Optional overflow flag output enabled by defining MULT_OVF_EN.
module booth_mult_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             isSigned,
  input  logic             multControl,
  output logic             busy,
  output logic             multStop,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULT_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned EW = WIDTH + 1;
  localparam int unsigned AW = 2 * WIDTH + 3;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [EW-1:0]    m_q, m_d;
  logic [EW-1:0]    negm_q, negm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             stop_q, stop_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [EW-1:0]    a_ext_c;
  logic [EW-1:0]    b_ext_c;
  logic [EW-1:0]    sum_c;
  logic [AW-1:0]    shifted_c;

`ifdef MULT_OVF_EN
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
`endif

  // Operand extension and one Booth add/shift step
  always_comb begin
    a_ext_c = isSigned ? {a[WIDTH-1], a} : {1'b0, a};
    b_ext_c = isSigned ? {b[WIDTH-1], b} : {1'b0, b};
    unique case (acc_q[1:0])
      2'b01:   sum_c = acc_q[AW-1 -: EW] + m_q;
      2'b10:   sum_c = acc_q[AW-1 -: EW] + negm_q;
      default: sum_c = acc_q[AW-1 -: EW];
    endcase
    shifted_c = {sum_c[EW-1], sum_c, acc_q[EW:1]};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    negm_d  = negm_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    stop_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULT_OVF_EN
    sign_d  = sign_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (multControl) begin
          acc_d   = {EW'(0), b_ext_c, 1'b0};
          m_d     = a_ext_c;
          negm_d  = EW'(0) - a_ext_c;
          cnt_d   = CNT_W'(EW);
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef MULT_OVF_EN
          sign_d  = isSigned;
`endif
        end
      end
      RUN: begin
        acc_d = shifted_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = shifted_c[2*WIDTH:WIDTH+1];
          lo_d    = shifted_c[WIDTH:1];
          stop_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef MULT_OVF_EN
          // Signed: hi must be pure sign extension of lo; unsigned: hi must be zero
          if (sign_q) ovf_d = (hi_d != {WIDTH{lo_d[WIDTH-1]}});
          else        ovf_d = (hi_d != '0);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      negm_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULT_OVF_EN
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      negm_q  <= negm_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULT_OVF_EN
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign multStop = stop_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
`ifdef MULT_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_booth_mult_param.sv
// Directed-vector bench for booth_mult_param at WIDTH=32 (ovf checked when MULT_OVF_EN is defined).
module tb_booth_mult_param;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             isSigned;
  logic             multControl;
  logic             busy;
  logic             multStop;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULT_OVF_EN
  logic             ovf;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  booth_mult_param #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .a           (a),
    .b           (b),
    .isSigned    (isSigned),
    .multControl (multControl),
    .busy        (busy),
    .multStop    (multStop),
    .hi          (hi),
    .lo          (lo)
`ifdef MULT_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] eh, input logic [31:0] el,
                           input logic eo);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
`ifdef MULT_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("unreachable");
`endif
  endtask

  // Pulse start for one cycle; returns at the negedge after the accepting edge
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic s);
    a           = av;
    b           = bv;
    isSigned    = s;
    multControl = 1'b1;
    @(negedge clk);
    multControl = 1'b0;
    a           = $urandom;
    b           = $urandom;
    isSigned    = 1'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    check("stop_low_after_start", 64'(multStop), 64'd0);
  endtask

  // Wait for done; optionally re-pulse start at cycle poke_at; checks latency, busy width, hold
  task automatic wait_done(input string tag, input int poke_at);
    int cyc    = 0;
    int busy_n = 0;
    int chg    = 0;
    logic [31:0] h0 = hi;
    logic [31:0] l0 = lo;
    while (!multStop && cyc < 100) begin
      if (busy) busy_n++;
      if (hi !== h0 || lo !== l0) chg++;
      if (cyc == poke_at) begin
        a = 32'd9; b = 32'd9; isSigned = 1'b0; multControl = 1'b1;
      end else begin
        multControl = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    multControl = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(LAT));
    check({tag, "_hold"}, 64'(chg), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int stops;
    int busies;
    Reset       = 1'b1;
    a           = '0;
    b           = '0;
    isSigned    = 1'b0;
    multControl = 1'b0;
    repeat (3) @(negedge clk);
    check_res("reset", 32'h0, 32'h0, 1'b0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stop", 64'(multStop), 64'd0);
    Reset = 1'b0;
    @(negedge clk);

    // 1: signed 7 x -3
    start_op(32'd7, 32'hFFFF_FFFD, 1'b1);
    wait_done("t1", -1);
    check_res("t1", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    check("t1_stop_one_cycle", 64'(multStop), 64'd0);
    check_res("t1_hold_after", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // 2: all-ones operands, unsigned then signed
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("t2u", -1);
    check_res("t2u", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("t2s", -1);
    check_res("t2s", 32'h0000_0000, 32'h0000_0001, 1'b0);

    // 3: signed extremes
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("t3a", -1);
    check_res("t3a", 32'h4000_0000, 32'h0000_0000, 1'b1);
    start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    wait_done("t3b", -1);
    check_res("t3b", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

    // Extra: signed negative x negative, unsigned a with top bit set
    start_op(32'hFFFF_FFF9, 32'hFFFF_FFFD, 1'b1);
    wait_done("tx1", -1);
    check_res("tx1", 32'h0, 32'd21, 1'b0);
    start_op(32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done("tx2", -1);
    check_res("tx2", 32'h1, 32'hFFFF_FFFE, 1'b1);

    // 4: start while busy is ignored
    start_op(32'd5, 32'd6, 1'b0);
    wait_done("t4", 9);
    check_res("t4", 32'h0, 32'h0000_001E, 1'b0);
    stops = 0;
    repeat (40) begin
      @(negedge clk);
      if (multStop) stops++;
    end
    check("t4_no_queued_op", 64'(stops), 64'd0);

    // 5: back-to-back, second start in the done cycle
    start_op(32'd2, 32'd3, 1'b0);
    wait_done("t5a", -1);
    check_res("t5a", 32'h0, 32'd6, 1'b0);
    start_op(32'd4, 32'd5, 1'b0);
    wait_done("t5b", -1);
    check_res("t5b", 32'h0, 32'h0000_0014, 1'b0);

    // 6: reset mid-operation aborts without done
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (14) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check_res("t6_abort", 32'h0, 32'h0, 1'b0);
    check("t6_abort_busy", 64'(busy), 64'd0);
    check("t6_abort_stop", 64'(multStop), 64'd0);
    stops  = 0;
    busies = 0;
    repeat (40) begin
      @(negedge clk);
      if (multStop) stops++;
      if (busy) busies++;
    end
    check("t6_no_stop", 64'(stops), 64'd0);
    check("t6_no_busy", 64'(busies), 64'd0);
    start_op(32'h1234_5678, 32'h0000_0010, 1'b0);
    wait_done("t6_fresh", -1);
    check_res("t6_fresh", 32'h0000_0001, 32'h2345_6780, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/booth_mult_param.md
Name: booth_mult_param

Overview:
- Parametrised iterative radix-2 Booth multiplier for the datapath's MULT/MULTU instructions.
- Produces a 2*WIDTH product split into hi/lo registers.
- Selects signed or unsigned per operation, and handshakes with the control FSM via a start pulse, a busy level and a one-cycle done pulse.
- Operand registers are captured at start, so a and b may change while the operation runs.

Parameters:
- WIDTH, 32, operand width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH+2), width of the internal iteration counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  multiplicand; sampled only on the start cycle.
- b  input  WIDTH  multiplier; sampled only on the start cycle.
- isSigned  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled on the start cycle.
- multControl  input  1  start request; one-cycle pulse, level also tolerated.
- busy  output  1  high while an operation is in progress.
- multStop  output  1  done pulse; exactly one cycle.
- hi  output  WIDTH  upper half of the product; registered.
- lo  output  WIDTH  lower half of the product; registered.
- ovf  output  1  present only with MULT_OVF_EN; see Optional Feature.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; busy=0; multStop=0; hi=0; lo=0; ovf=0; counter=0; internal accumulator cleared.
- FSM has two states: IDLE and RUN.
- IDLE: if multControl=1, load the operands and go to RUN with counter=WIDTH+1 and busy=1.
- Operand load rules:
  - Extend both operands to WIDTH+1 bits: sign-extend when isSigned=1, zero-extend when isSigned=0.
  - Accumulator = {(WIDTH+1) zeros, b_ext, 1'b0}, 2*WIDTH+3 bits.
  - Store M = a_ext and −M (two's complement, WIDTH+1 bits).
- RUN, each cycle, using the accumulator's two LSBs:
  - 01: add M to the upper WIDTH+1 bits.
  - 10: add −M to the upper WIDTH+1 bits.
  - 00 or 11: no add.
  - Then arithmetic-shift the whole accumulator right by 1, replicating the MSB.
  - counter decrements by 1.
- The step that brings counter to 0 is the last:
  - At that same edge, write hi/lo = accumulator bits [2*WIDTH:1] after the final shift; the extra sign bit is dropped.
  - Assert multStop=1, busy=0, and return to IDLE.
- Latency: multControl sampled at edge N gives multStop high and hi/lo valid in the cycle after edge N+WIDTH+1. For WIDTH=32 this is 33 cycles.
- hi/lo hold their value until the next completion or Reset. They are never cleared by a new start.
- multControl while busy=1 is ignored: no restart and no queueing.
- multControl in the same cycle that multStop=1 is accepted, because the FSM is already in IDLE. This gives back-to-back throughput of one result per WIDTH+1 cycles.
- Reset during RUN aborts immediately with no multStop pulse. hi/lo return to 0.
- Edge cases need no special-case logic:
  - Unsigned a=2^WIDTH−1 is correct because of the WIDTH+1 extension.
  - Signed most-negative × most-negative gives 2^(2*WIDTH−2).
- Arithmetic is modulo 2^(2*WIDTH+2) internally. The result is exact for all operand and mode combinations.

Optional Feature:
- Macro: MULT_OVF_EN.
- Defined:
  - Port ovf exists and is registered with hi/lo at completion.
  - Signed mode: ovf=1 when hi is not all copies of lo[WIDTH-1], i.e. the product does not fit in WIDTH signed bits.
  - Unsigned mode: ovf=1 when hi≠0.
  - ovf holds until the next completion; Reset clears it.
- Not defined: port ovf and all its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=32):
1. Signed: a=7, b=−3 (FFFFFFFD), isSigned=1, pulse start → multStop after 33 cycles; hi=FFFFFFFF, lo=FFFFFFEB; busy high for exactly 33 cycles; ovf=0.
2. Unsigned: a=b=FFFFFFFF, isSigned=0 → hi=FFFFFFFE, lo=00000001, ovf=1. Same operands with isSigned=1 → hi=00000000, lo=00000001, ovf=0.
3. Signed extremes: a=b=80000000 → hi=40000000, lo=00000000. Then a=80000000, b=00000001 → hi=FFFFFFFF, lo=80000000, ovf=0.
4. Start while busy: start 5×6, re-pulse start with 9×9 at cycle 10 → single multStop at cycle 33 with hi=0, lo=0000001E.
5. Back-to-back: start 2×3 at cycle 0, start 4×5 in the multStop cycle → lo=6, then exactly 33 cycles later lo=00000014; hi/lo stable in between.
6. Reset at cycle 15 of 12345678×9ABCDEF0 → hi=lo=0 and busy=0 next cycle, no multStop. A fresh start afterwards gives the correct result.
